// File: rtl/lwr_multi_dot_if.sv
// ============================================================================
// lwr_multi_dot_if : element stream and result handshake for lwr_multi_dot
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface lwr_multi_dot_if #(
  parameter int ELEM_WIDTH = 12,
  parameter int NUM_CH     = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int LOG_P      = 8
);
  logic                        start;
  logic [ELEM_WIDTH-1:0]       a_in;
  logic                        a_valid;
  logic                        a_last;
  logic                        a_ready;
  logic [NUM_CH-1:0]           key_bits;
  logic [NUM_CH*ACC_WIDTH-1:0] res_dot;
  logic [NUM_CH*LOG_P-1:0]     res_round;
  logic                        res_valid;
  logic                        res_ready;
  logic                        busy;
  logic                        len_err;

  modport master (
    output start, a_in, a_valid, a_last, key_bits, res_ready,
    input  a_ready, res_dot, res_round, res_valid, busy, len_err
  );

  modport slave (
    input  start, a_in, a_valid, a_last, key_bits, res_ready,
    output a_ready, res_dot, res_round, res_valid, busy, len_err
  );
endinterface

`default_nettype wire

// File: rtl/lwr_multi_dot.sv
// ============================================================================
// lwr_multi_dot : streams one vector a against NUM_CH binary keys, producing
//                 raw dot products and their LWR rounding from q to p.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lwr_multi_dot #(
  parameter int N_LWR      = 445,
  parameter int ELEM_WIDTH = 12,
  parameter int NUM_CH     = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int LOG_P      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  lwr_multi_dot_if.slave    bus
);

  localparam int                    c_cnt_w   = $clog2(N_LWR + 2);
  localparam logic [c_cnt_w-1:0]    c_cnt_max = c_cnt_w'(N_LWR + 1);
  localparam logic [c_cnt_w-1:0]    c_n_lwr   = c_cnt_w'(N_LWR);
  localparam logic [c_cnt_w-1:0]    c_cnt_one = c_cnt_w'(1);
  localparam int                    c_shift   = ELEM_WIDTH - LOG_P;
  localparam logic [ELEM_WIDTH-1:0] c_half    = ELEM_WIDTH'(1) << (c_shift - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_a_ready;
  logic               w_clear;
  logic               w_beat;
  logic               w_done;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               r_len_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_a_ready = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_clear = 1'b1;
          w_next  = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // A start pulse restarts the vector and blocks that cycle's beat.
        w_a_ready = !bus.start;
        w_clear   = bus.start;
        if (bus.a_valid && !bus.start && bus.a_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_beat    = w_a_ready & bus.a_valid;
  assign w_done    = w_beat & bus.a_last;
  assign w_cnt_inc = r_cnt + c_cnt_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (w_beat) begin
      if (r_cnt != c_cnt_max) r_cnt <= w_cnt_inc;
      // Once saturated the increment may wrap, but never onto N_LWR.
      if (w_done) r_len_err <= (w_cnt_inc != c_n_lwr);
    end else if ((r_state == S_HOLD) && bus.res_ready) begin
      r_len_err <= 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH-1:0]  r_dot;
    logic [LOG_P-1:0]      r_rnd;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic [ELEM_WIDTH-1:0] w_v;
    logic [LOG_P-1:0]      w_rnd;

    assign w_sum = r_acc + (bus.key_bits[c] ? {{(ACC_WIDTH-ELEM_WIDTH){1'b0}}, bus.a_in}
                                            : {ACC_WIDTH{1'b0}});
    assign w_v   = w_sum[ELEM_WIDTH-1:0];
    // The ELEM_WIDTH-bit add wraps mod q, which yields exactly the mod-p result.
    assign w_rnd = LOG_P'((w_v + c_half) >> c_shift);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
        r_dot <= '0;
        r_rnd <= '0;
      end else begin
        if (w_clear)     r_acc <= '0;
        else if (w_beat) r_acc <= w_sum;
        if (w_done) begin
          r_dot <= w_sum;
          r_rnd <= w_rnd;
        end
      end
    end

    assign bus.res_dot[c*ACC_WIDTH +: ACC_WIDTH] = r_dot;
    assign bus.res_round[c*LOG_P +: LOG_P]       = r_rnd;
  end

  assign bus.a_ready   = w_a_ready;
  assign bus.res_valid = (r_state == S_HOLD);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.len_err   = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_lwr_multi_dot.sv
// ============================================================================
// tb_lwr_multi_dot : directed and randomized checks of lwr_multi_dot against
//                    a sum-of-accepted-beats reference model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lwr_multi_dot;
  localparam int N_LWR      = 4;
  localparam int ELEM_WIDTH = 12;
  localparam int NUM_CH     = 4;
  localparam int ACC_WIDTH  = 32;
  localparam int LOG_P      = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lwr_multi_dot_if #(.ELEM_WIDTH(ELEM_WIDTH), .NUM_CH(NUM_CH), .ACC_WIDTH(ACC_WIDTH),
                     .LOG_P(LOG_P)) bus ();

  lwr_multi_dot #(.N_LWR(N_LWR), .ELEM_WIDTH(ELEM_WIDTH), .NUM_CH(NUM_CH),
                  .ACC_WIDTH(ACC_WIDTH), .LOG_P(LOG_P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Beats the DUT should have accepted for the current vector.
  int unsigned       q_a[$];
  logic [NUM_CH-1:0] q_k[$];

  task automatic chk(input string tag, input logic [ACC_WIDTH-1:0] obs,
                     input logic [ACC_WIDTH-1:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint model_dot(input int c);
    longint s = 0;
    foreach (q_a[i]) if (q_k[i][c]) s += q_a[i];
    return s;
  endfunction

  function automatic int model_round(input int c);
    longint v = model_dot(c) % (64'd1 << ELEM_WIDTH);
    return int'(((v + (64'd1 << (ELEM_WIDTH-LOG_P-1))) / (64'd1 << (ELEM_WIDTH-LOG_P)))
                % (64'd1 << LOG_P));
  endfunction

  function automatic logic [ACC_WIDTH-1:0] dot_of(input int c);
    return bus.res_dot[c*ACC_WIDTH +: ACC_WIDTH];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] rnd_of(input int c);
    return ACC_WIDTH'(bus.res_round[c*LOG_P +: LOG_P]);
  endfunction

  task automatic do_start();
    bus.start   = 1'b1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    q_a.delete();
    q_k.delete();
  endtask

  task automatic beat(input int unsigned a, input logic [NUM_CH-1:0] k, input logic last,
                      input bit stalls);
    if (stalls) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.a_valid  = 1'b0;
        bus.a_in     = ELEM_WIDTH'($urandom);
        bus.key_bits = NUM_CH'($urandom);
        bus.a_last   = 1'($urandom);
        @(negedge clk);
      end
    end
    bus.a_in     = ELEM_WIDTH'(a);
    bus.key_bits = k;
    bus.a_last   = last;
    bus.a_valid  = 1'b1;
    #1 chk("a_ready_accum", ACC_WIDTH'(bus.a_ready), 1);
    q_a.push_back(a);
    q_k.push_back(k);
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.a_last  = 1'b0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".res_valid"}, ACC_WIDTH'(bus.res_valid), 1);
    chk({tag, ".busy"},      ACC_WIDTH'(bus.busy), 1);
    chk({tag, ".a_ready"},   ACC_WIDTH'(bus.a_ready), 0);
    chk({tag, ".len_err"},   ACC_WIDTH'(bus.len_err), ACC_WIDTH'(q_a.size() != N_LWR));
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("%s.dot%0d", tag, c),   dot_of(c), ACC_WIDTH'(model_dot(c)));
      chk($sformatf("%s.round%0d", tag, c), rnd_of(c), ACC_WIDTH'(model_round(c)));
    end
  endtask

  task automatic accept(input string tag);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, ".acc_valid"},   ACC_WIDTH'(bus.res_valid), 0);
    chk({tag, ".acc_busy"},    ACC_WIDTH'(bus.busy), 0);
    chk({tag, ".acc_len_err"}, ACC_WIDTH'(bus.len_err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned       s1_a[4];
    logic [NUM_CH-1:0] s1_k[4];
    int                len;

    s1_a = '{100, 200, 300, 400};
    s1_k = '{4'b0011, 4'b0001, 4'b0011, 4'b1001};

    bus.start = 1'b0; bus.a_in = '0; bus.a_valid = 1'b0; bus.a_last = 1'b0;
    bus.key_bits = '0; bus.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.res_valid", ACC_WIDTH'(bus.res_valid), 0);
    chk("rst.busy",      ACC_WIDTH'(bus.busy), 0);
    chk("rst.a_ready",   ACC_WIDTH'(bus.a_ready), 0);
    chk("rst.len_err",   ACC_WIDTH'(bus.len_err), 0);
    for (int c = 0; c < NUM_CH; c++) begin
      chk("rst.dot", dot_of(c), 0);
      chk("rst.round", rnd_of(c), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // a_valid while idle must be ignored
    bus.a_valid = 1'b1; bus.a_in = 12'd123; bus.key_bits = '1; bus.a_last = 1'b1;
    repeat (3) begin
      #1 chk("idle.a_ready", ACC_WIDTH'(bus.a_ready), 0);
      @(negedge clk);
    end
    chk("idle.busy", ACC_WIDTH'(bus.busy), 0);
    bus.a_valid = 1'b0; bus.a_last = 1'b0;

    // Basic vector
    do_start();
    for (int i = 0; i < 4; i++) beat(s1_a[i], s1_k[i], i == 3, 1'b0);
    check_result("s1");
    chk("s1.dot0_const", dot_of(0), 1000);
    chk("s1.dot1_const", dot_of(1), 400);
    chk("s1.dot3_const", dot_of(3), 400);
    chk("s1.rnd0_const", rnd_of(0), 63);
    chk("s1.rnd1_const", rnd_of(1), 25);
    accept("s1");

    // Wrap / rounding, then backpressure with ignored starts
    do_start();
    for (int i = 0; i < 4; i++) beat(4095, (i == 0) ? 4'b0011 : 4'b0001, i == 3, 1'b0);
    check_result("wrap");
    chk("wrap.dot0_const", dot_of(0), 16380);
    chk("wrap.rnd0_const", rnd_of(0), 0);
    chk("wrap.dot1_const", dot_of(1), 4095);
    chk("wrap.rnd1_const", rnd_of(1), 0);
    repeat (10) begin
      bus.start   = 1'($urandom);
      bus.a_valid = 1'($urandom);
      bus.a_last  = 1'b1;
      #1 check_result("bp");
      @(negedge clk);
    end
    bus.start = 1'b0; bus.a_valid = 1'b0; bus.a_last = 1'b0;
    accept("bp");

    // Same vector with random input stalls
    do_start();
    for (int i = 0; i < 4; i++) beat(s1_a[i], s1_k[i], i == 3, 1'b1);
    check_result("stall");
    accept("stall");

    // Short and long vectors
    do_start();
    for (int i = 0; i < 3; i++) beat(s1_a[i], 4'b0001, i == 2, 1'b0);
    check_result("short");
    chk("short.dot0_const", dot_of(0), 600);
    chk("short.len_const",  ACC_WIDTH'(bus.len_err), 1);
    accept("short");
    do_start();
    for (int i = 0; i < 7; i++) beat($urandom_range(0, 4095), NUM_CH'($urandom), i == 6, 1'b0);
    check_result("long");
    chk("long.len_const", ACC_WIDTH'(bus.len_err), 1);
    accept("long");

    // Restart mid-vector
    do_start();
    beat(777, 4'b1111, 1'b0, 1'b0);
    beat(888, 4'b1111, 1'b0, 1'b0);
    bus.start = 1'b1; bus.a_valid = 1'b1; bus.a_in = 12'd999; bus.key_bits = 4'b1111;
    #1 chk("restart.a_ready", ACC_WIDTH'(bus.a_ready), 0);
    @(negedge clk);
    bus.start = 1'b0; bus.a_valid = 1'b0;
    q_a.delete(); q_k.delete();
    for (int i = 0; i < 4; i++) beat(s1_a[i], s1_k[i], i == 3, 1'b0);
    check_result("restart");
    accept("restart");

    // Randomized vectors
    for (int t = 0; t < 10; t++) begin
      len = (t % 2 == 0) ? N_LWR : int'($urandom_range(1, 7));
      do_start();
      for (int i = 0; i < len; i++)
        beat($urandom_range(0, 4095), NUM_CH'($urandom), i == len - 1, 1'b1);
      repeat ($urandom_range(1, 3)) begin
        check_result($sformatf("rnd%0d", t));
        @(negedge clk);
      end
      accept($sformatf("rnd%0d", t));
    end

    // Asynchronous reset in the middle of accumulation
    do_start();
    beat(1234, 4'b1111, 1'b0, 1'b0);
    beat(2345, 4'b1111, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst.res_valid", ACC_WIDTH'(bus.res_valid), 0);
    chk("mrst.busy",      ACC_WIDTH'(bus.busy), 0);
    chk("mrst.len_err",   ACC_WIDTH'(bus.len_err), 0);
    for (int c = 0; c < NUM_CH; c++) begin
      chk("mrst.dot", dot_of(c), 0);
      chk("mrst.round", rnd_of(c), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.a_valid = 1'b1;
    @(negedge clk);
    #1 chk("mrst.a_ready", ACC_WIDTH'(bus.a_ready), 0);
    chk("mrst.idle", ACC_WIDTH'(bus.busy), 0);
    bus.a_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
